// File: rtl/cam_stream_emulator.sv
// cam_stream_emulator
//   OV7670-style 8-bit parallel camera transmitter. Emits RGB565 pixels,
//   high byte first, with pclk/vsync/href framing, so that the capture chain
//   can be driven with known, deterministic frames.
//
//   Optional feature macro: CAM_STREAM_NOISE_EN
//     When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed ACE1)
//     advances once per pixel and flips the LSB of R, G and B through the
//     mask 16'h0821. The byte-ramp pattern is never altered.
//
//   Ports
//     clk_in           system clock
//     reset_n_in       asynchronous active-low reset
//     enable_in        permits frame generation (sampled between frames)
//     pattern_in       00 bars, 01 gradient, 10 red box, 11 byte ramp
//     box_x_in/box_y_in red box top-left corner (pixels)
//     pclk_out         free-running pixel clock, PCLK_DIV clk_in per half
//     vsync_out        frame sync, active high
//     href_out         line valid, active high
//     pixel_data_out   pixel byte
//     frame_count_out  completed frames (wraps)
//     frame_start_out  one clk_in pulse as vsync_out rises
module cam_stream_emulator #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PCLK_DIV    = 2,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_in,
  input  logic [8:0]  box_x_in,
  input  logic [7:0]  box_y_in,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  pixel_data_out,
  output logic [15:0] frame_count_out,
  output logic        frame_start_out
);

  localparam int LINE    = 2*WIDTH + HBLANK;
  localparam int BYTES   = 2*WIDTH;
  localparam int VS_CYC  = VSYNC_LINES*LINE;
  localparam int VBP_CYC = VBP_LINES*LINE;
  localparam int VFP_CYC = VFP_LINES*LINE;
  localparam int CW      = $clog2((VSYNC_LINES + VBP_LINES + VFP_LINES)*LINE + 1);
  localparam int LW      = $clog2(HEIGHT + 1);
  localparam int DW      = $clog2(PCLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBL, VFP} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [CW-1:0]   cnt;      // pclk cycles in a blank state, byte index in ACTIVE
  logic [LW-1:0]   line;
  logic [1:0]      pat_q;
  logic [8:0]      bx_q;
  logic [7:0]      by_q;

  logic            pclk_fall, vfp_done, start_frame, box_hit;
  logic [CW-1:0]   nxt_idx;
  logic [LW-1:0]   nxt_line;
  logic [9:0]      px_x, px_y;
  logic [15:0]     pix;
  logic [7:0]      nxt_byte;

`ifdef CAM_STREAM_NOISE_EN
  logic [15:0]     lfsr;
`endif

  assign pclk_fall   = (div_cnt == DW'(PCLK_DIV-1)) && pclk_out;
  assign vfp_done    = (state == VFP) && (cnt == CW'(VFP_CYC-1));
  // The end of the front porch doubles as the idle slot, so back-to-back
  // frames repeat every (VSYNC+VBP+HEIGHT+VFP) line periods exactly.
  assign start_frame = pclk_fall && enable_in && ((state == IDLE) || vfp_done);

  // Byte that will be presented at the next pclk fall.
  always_comb begin
    nxt_idx  = '0;
    nxt_line = line;
    if (state == ACTIVE) nxt_idx = cnt + CW'(1);
    if (state == HBL)      nxt_line = line + LW'(1);
    else if (state == VBP) nxt_line = '0;
    px_x = 10'(nxt_idx >> 1);
    px_y = 10'(nxt_line);
    // 10-bit compares: the box clips at the right/bottom edge instead of wrapping.
    box_hit = (px_x >= {1'b0, bx_q}) && (px_x < {1'b0, bx_q} + 10'd16) &&
              (px_y >= {2'b0, by_q}) && (px_y < {2'b0, by_q} + 10'd16);
    pix = '0;
    case (pat_q)
      2'b00: begin
        case (px_x[8:6])
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'b01:   pix = {px_x[8:4], px_y[7:2], 5'b0};
      2'b10:   pix = box_hit ? 16'hF800 : 16'h0000;
      default: pix = '0;
    endcase
`ifdef CAM_STREAM_NOISE_EN
    pix = pix ^ (lfsr & 16'h0821);
`endif
    if (pat_q == 2'b11) nxt_byte = 8'(nxt_idx);
    else                nxt_byte = nxt_idx[0] ? pix[7:0] : pix[15:8];
  end

`ifdef CAM_STREAM_NOISE_EN
  // Steps when a pixel's low byte goes out, so both bytes share one value.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) lfsr <= 16'hACE1;
    else if (pclk_fall && (state == ACTIVE) && !cnt[0])
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= IDLE;
      div_cnt         <= '0;
      cnt             <= '0;
      line            <= '0;
      pat_q           <= '0;
      bx_q            <= '0;
      by_q            <= '0;
      pclk_out        <= 1'b0;
      vsync_out       <= 1'b0;
      href_out        <= 1'b0;
      pixel_data_out  <= '0;
      frame_count_out <= '0;
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      if (div_cnt == DW'(PCLK_DIV-1)) begin
        div_cnt  <= '0;
        pclk_out <= ~pclk_out;
      end else begin
        div_cnt  <= div_cnt + DW'(1);
      end

      if (pclk_fall) begin
        case (state)
          VSYNC: begin
            if (cnt == CW'(VS_CYC-1)) begin
              cnt       <= '0;
              vsync_out <= 1'b0;
              state     <= VBP;
            end else cnt <= cnt + CW'(1);
          end
          VBP: begin
            if (cnt == CW'(VBP_CYC-1)) begin
              cnt            <= '0;
              line           <= '0;
              href_out       <= 1'b1;
              pixel_data_out <= nxt_byte;
              state          <= ACTIVE;
            end else cnt <= cnt + CW'(1);
          end
          ACTIVE: begin
            if (cnt == CW'(BYTES-1)) begin
              cnt            <= '0;
              href_out       <= 1'b0;
              pixel_data_out <= '0;
              state          <= HBL;
            end else begin
              cnt            <= cnt + CW'(1);
              pixel_data_out <= nxt_byte;
            end
          end
          HBL: begin
            if (cnt == CW'(HBLANK-1)) begin
              cnt <= '0;
              if (line < LW'(HEIGHT-1)) begin
                line           <= nxt_line;
                href_out       <= 1'b1;
                pixel_data_out <= nxt_byte;
                state          <= ACTIVE;
              end else state <= VFP;
            end else cnt <= cnt + CW'(1);
          end
          VFP: begin
            if (vfp_done) begin
              cnt             <= '0;
              frame_count_out <= frame_count_out + 16'd1;
              state           <= IDLE;
            end else cnt <= cnt + CW'(1);
          end
          default: ;
        endcase

        // Frame inputs are captured only here, never mid-frame.
        if (start_frame) begin
          pat_q           <= pattern_in;
          bx_q            <= box_x_in;
          by_q            <= box_y_in;
          cnt             <= '0;
          vsync_out       <= 1'b1;
          frame_start_out <= 1'b1;
          state           <= VSYNC;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_emulator.sv
// Bench for cam_stream_emulator with a reduced frame geometry.
module tb_cam_stream_emulator;

  localparam int W = 130, H = 10, PD = 2, HB = 6, VSL = 1, VBL = 1, VFL = 1;
  localparam int L = 2*W + HB;
  localparam int FRAME = (VSL + VBL + H + VFL)*L;
  localparam int FB = FRAME*2*PD + 2000;

  logic clk, rst_n, en;
  logic [1:0] pat;
  logic [8:0] bx;
  logic [7:0] by;
  logic pclk, vsync, href, fs;
  logic [7:0] data;
  logic [15:0] fcnt;

  int tests = 0, fails = 0;

  cam_stream_emulator #(
    .WIDTH(W), .HEIGHT(H), .PCLK_DIV(PD), .HBLANK(HB),
    .VSYNC_LINES(VSL), .VBP_LINES(VBL), .VFP_LINES(VFL)
  ) dut (
    .clk_in(clk), .reset_n_in(rst_n), .enable_in(en), .pattern_in(pat),
    .box_x_in(bx), .box_y_in(by), .pclk_out(pclk), .vsync_out(vsync),
    .href_out(href), .pixel_data_out(data), .frame_count_out(fcnt),
    .frame_start_out(fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern rules straight from the pattern definitions.
  function automatic logic [7:0] exp_byte(input logic [1:0] p, input int bxv,
                                          input int byv, input int ln, input int bi);
    int x;
    logic [15:0] px;
    x  = bi / 2;
    px = 16'h0;
    case (p)
      2'b00: case ((x / 64) % 8)
               0: px = 16'hFFFF; 1: px = 16'hFFE0; 2: px = 16'h07FF; 3: px = 16'h07E0;
               4: px = 16'hF81F; 5: px = 16'hF800; 6: px = 16'h001F; default: px = 16'h0000;
             endcase
      2'b01: px = 16'(((x / 16) % 32)*2048 + ((ln / 4) % 64)*32);
      2'b10: px = (x >= bxv && x < bxv + 16 && ln >= byv && ln < byv + 16) ? 16'hF800 : 16'h0000;
      default: return 8'(bi % 256);
    endcase
    return (bi % 2 == 1) ? px[7:0] : px[15:8];
  endfunction

  // Inputs as the DUT saw them at the last rising clk edge.
  logic s_en;
  logic [1:0] s_pat;
  logic [8:0] s_bx;
  logic [7:0] s_by;
  always @(posedge clk) begin
    s_en  <= en;
    s_pat <= pat;
    s_bx  <= bx;
    s_by  <= by;
  end

  // Timeline model: k counts clk edges since reset release, p counts pclk
  // periods since the current frame's vsync rise.
  int k = 0, p = 0, m_bx = 0, m_by = 0;
  bit busy = 0, m_fs = 0;
  logic [1:0] m_pat = 0;
  logic [15:0] m_cnt = 0;
  always @(negedge clk) begin
    int lp;
    logic e_pclk, e_vs, e_href;
    logic [7:0] e_data;
    if (!rst_n) begin
      k = 0; p = 0; busy = 0; m_fs = 0; m_cnt = 0;
      chk("reset_outputs", {pclk, vsync, href, data, fs, fcnt}, 0);
    end else begin
      k++;
      m_fs = 0;
      if (k % (2*PD) == 0) begin
        if (busy) begin
          p++;
          if (p == FRAME) begin
            m_cnt = m_cnt + 16'd1;
            busy  = 0;
          end
        end
        if (!busy && s_en) begin
          busy = 1; p = 0; m_fs = 1;
          m_pat = s_pat; m_bx = int'(s_bx); m_by = int'(s_by);
        end
      end
      e_pclk = ((k / PD) % 2) == 1;
      e_vs   = busy && p < VSL*L;
      lp     = p - (VSL + VBL)*L;
      e_href = busy && lp >= 0 && lp < H*L && (lp % L) < 2*W;
      e_data = e_href ? exp_byte(m_pat, m_bx, m_by, lp / L, lp % L) : 8'h00;
      chk("cycle_outputs", {pclk, vsync, href, data, fs, fcnt},
          {e_pclk, e_vs, e_href, e_data, m_fs, m_cnt});
    end
  end

  // Bytes of the current frame as seen at pclk rising edges.
  logic [7:0] cap [H][2*W];
  int cap_ln = 0, cap_bi = 0, href_pulses = 0;
  logic prev_pclk = 0, prev_href = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cap_ln = 0; cap_bi = 0; href_pulses = 0; prev_pclk = 0; prev_href = 0;
    end else begin
      if (fs) begin
        cap_ln = 0; cap_bi = 0; href_pulses = 0;
      end
      if (pclk && !prev_pclk && href && cap_ln < H && cap_bi < 2*W) begin
        cap[cap_ln][cap_bi] = data;
        cap_bi++;
      end
      if (prev_href && !href) begin
        cap_ln++; cap_bi = 0; href_pulses++;
      end
      prev_pclk = pclk;
      prev_href = href;
    end
  end

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (fcnt != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame_count", int'(fcnt), target);
  endtask

  task automatic wait_fs(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < budget);
    chk("wait_frame_start", int'(fs), 1);
  endtask

  initial begin
    int n;
    logic p0;
    rst_n = 0; en = 0; pat = 2'b00; bx = 0; by = 0;

    // Pin the model against hand-worked values at full-size coordinates.
    chk("model_box_100_50_px100", exp_byte(2'b10, 100, 50, 50, 200), 8'hF8);
    chk("model_box_px115_lo",     exp_byte(2'b10, 100, 50, 50, 231), 8'h00);
    chk("model_box_px116",        exp_byte(2'b10, 100, 50, 50, 232), 8'h00);
    chk("model_box_line66",       exp_byte(2'b10, 100, 50, 66, 200), 8'h00);
    chk("model_box_clip_319_239", exp_byte(2'b10, 310, 235, 239, 638), 8'hF8);
    chk("model_box_clip_309",     exp_byte(2'b10, 310, 235, 239, 618), 8'h00);
    chk("model_ramp_300",         exp_byte(2'b11, 0, 0, 3, 300), 8'd44);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {pclk, vsync, href, data, fs, fcnt}, 0);
    @(negedge clk);
    #1 rst_n = 1; en = 1;

    // Frame 1: colour bars
    wait_fs(50, n);
    chk("first_fs_latency", n, 2*PD);
    pat = 2'b01;
    wait_count(1, FB);
    chk("bars_px0_hi",   cap[0][0],   8'hFF);
    chk("bars_px64_lo",  cap[0][129], 8'hE0);
    chk("bars_px128_hi", cap[3][256], 8'h07);
    chk("bars_px128_lo", cap[3][257], 8'hFF);

    // Frame 2: gradient
    pat = 2'b10; bx = 9'd120; by = 8'd6;
    wait_count(2, FB);
    chk("grad_x37_y9_hi", cap[9][74], 8'h10);
    chk("grad_x37_y9_lo", cap[9][75], 8'h40);

    // Frame 3: box at (120,6), clipped; box moves mid-frame
    bx = 9'd3; by = 8'd2;
    wait_count(3, FB);
    chk("box_px120_hi",    cap[6][240], 8'hF8);
    chk("box_px120_lo",    cap[6][241], 8'h00);
    chk("box_px129_line9", cap[9][258], 8'hF8);
    chk("box_line5",       cap[5][240], 8'h00);
    chk("box_px119",       cap[6][238], 8'h00);

    // Frame 4: moved box; enable dropped during line 5
    pat = 2'b11;
    repeat ((VSL + VBL + 5)*L*2*PD + 50) @(negedge clk);
    en = 0;
    wait_count(4, FB);
    chk("box2_px3",         cap[2][6],  8'hF8);
    chk("box2_px18",        cap[2][36], 8'hF8);
    chk("box2_px19",        cap[2][38], 8'h00);
    chk("box2_line1",       cap[1][6],  8'h00);
    chk("href_pulses",      href_pulses, H);
    repeat (200) @(negedge clk);
    chk("idle_vsync_low",   int'(vsync), 0);
    chk("idle_count_held",  int'(fcnt), 4);
    p0 = pclk;
    repeat (PD) @(negedge clk);
    chk("idle_pclk_toggle", int'(pclk), int'(!p0));

    // Frame 5: reset in the middle of line 3
    en = 1;
    wait_fs(100, n);
    repeat ((VSL + VBL + 3)*L*2*PD + 400) @(negedge clk);
    chk("href_before_reset", int'(href), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", {pclk, vsync, href, data}, 0);
    chk("async_reset_count",   int'(fcnt), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1;

    // Frame 6: byte ramp after reset
    wait_fs(50, n);
    chk("restart_fs_latency", n, 2*PD);
    chk("restart_count",      int'(fcnt), 0);
    wait_count(1, FB);
    chk("ramp_255", cap[0][255], 8'hFF);
    chk("ramp_256", cap[0][256], 8'h00);
    chk("ramp_259", cap[0][259], 8'h03);
    chk("ramp_l4_17", cap[4][17], 8'h11);
    en = 0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
